// File: rtl/bin_bcd_seq_conv.sv
`default_nettype none
// ============================================================================
// Module      : bin_bcd_seq_conv
// Description : Multi-cycle bidirectional binary/BCD converter.
//               mode 0 : binary -> BCD, shift-add-3, one bit per cycle
//               mode 1 : BCD -> binary, acc*10 + digit, one digit per cycle
// Ports       : clk, rst_n (async, active-low)
//               in_valid / in_ready   : request handshake
//               mode, bin_in, bcd_in  : request (sampled at acceptance)
//               out_valid / out_ready : result handshake
//               bcd_out, bin_out      : results (the unused one reads 0)
//               ovf, err, mode_out    : truncation, bad-digit, result mode
// Revision    : 1.0 - initial release
// ============================================================================
module bin_bcd_seq_conv #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  err,
    output logic                  mode_out
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam int             c_bcd_w    = 4 * DIGITS;
    localparam int             c_prod_w   = BIN_W + 4;
    localparam logic [CNT_W-1:0] c_bin_last = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] c_dig_last = CNT_W'(DIGITS - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;

    logic                r_mode;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]    r_bin_sh;   // mode 0: binary bits still to shift in
    logic [c_bcd_w-1:0]  r_bcd_sh;   // mode 0: BCD digits being built
    logic [BIN_W-1:0]    r_acc;      // mode 1: binary accumulator
    logic [c_bcd_w-1:0]  r_src;      // mode 1: remaining digits, next at top
    logic                r_ovf_acc;
    logic                r_err_acc;

    logic [c_bcd_w-1:0]  r_bcd_out;
    logic [BIN_W-1:0]    r_bin_out;
    logic                r_ovf;
    logic                r_err;
    logic                r_mode_out;

    logic [c_bcd_w-1:0]  w_bcd_adj;
    logic [c_bcd_w-1:0]  w_bcd_next;
    logic [BIN_W-1:0]    w_bin_next;
    logic                w_shift_out;
    logic [3:0]          w_digit;
    logic [c_prod_w-1:0] w_prod;
    logic                w_acc_ovf;
    logic                w_digit_err;
    logic                w_ovf_now;
    logic                w_last;

    // ------------------------------------------------------------------
    // Mode 0 datapath: add-3 correction on every digit, then shift left.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        assign w_bcd_adj[4*gi +: 4] = (r_bcd_sh[4*gi +: 4] >= 4'd5)
                                    ? r_bcd_sh[4*gi +: 4] + 4'd3
                                    : r_bcd_sh[4*gi +: 4];
    end

    // The bit leaving the top digit is a 10^DIGITS carry that the result
    // cannot hold, so it marks truncation.
    assign w_shift_out = w_bcd_adj[c_bcd_w-1];
    assign w_bcd_next  = {w_bcd_adj[c_bcd_w-2:0], r_bin_sh[BIN_W-1]};
    assign w_bin_next  = {r_bin_sh[BIN_W-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Mode 1 datapath: acc*10 + digit computed 4 bits wider than acc so
    // that any carry beyond BIN_W is visible as overflow.
    // ------------------------------------------------------------------
    assign w_digit     = r_src[c_bcd_w-1 -: 4];
    assign w_prod      = ({4'd0, r_acc} << 3) + ({4'd0, r_acc} << 1)
                       + c_prod_w'(w_digit);
    assign w_acc_ovf   = |w_prod[c_prod_w-1:BIN_W];
    assign w_digit_err = (w_digit > 4'd9);

    assign w_ovf_now = r_mode ? w_acc_ovf : w_shift_out;
    assign w_last    = r_mode ? (r_cnt == c_dig_last) : (r_cnt == c_bin_last);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (in_valid)  w_next_state = c_run;
            c_run:   if (w_last)    w_next_state = c_done;
            c_done:  if (out_ready) w_next_state = c_idle;
            default:                w_next_state = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == c_idle);
        out_valid = (r_state == c_done);
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= 1'b0;
            r_cnt      <= '0;
            r_bin_sh   <= '0;
            r_bcd_sh   <= '0;
            r_acc      <= '0;
            r_src      <= '0;
            r_ovf_acc  <= 1'b0;
            r_err_acc  <= 1'b0;
            r_bcd_out  <= '0;
            r_bin_out  <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_mode_out <= 1'b0;
        end else begin
            if (r_state == c_idle && in_valid) begin
                r_mode    <= mode;
                r_bin_sh  <= bin_in;
                r_bcd_sh  <= '0;
                r_acc     <= '0;
                r_src     <= bcd_in;
                r_cnt     <= '0;
                r_ovf_acc <= 1'b0;
                r_err_acc <= 1'b0;
            end else if (r_state == c_run) begin
                r_cnt     <= r_cnt + CNT_W'(1);
                r_ovf_acc <= r_ovf_acc | w_ovf_now;
                if (!r_mode) begin
                    r_bcd_sh <= w_bcd_next;
                    r_bin_sh <= w_bin_next;
                end else begin
                    r_acc     <= w_prod[BIN_W-1:0];
                    r_src     <= {r_src[c_bcd_w-5:0], 4'd0};
                    r_err_acc <= r_err_acc | w_digit_err;
                end
                if (w_last) begin
                    r_mode_out <= r_mode;
                    r_ovf      <= r_ovf_acc | w_ovf_now;
                    r_bcd_out  <= r_mode ? '0 : w_bcd_next;
                    r_bin_out  <= r_mode ? w_prod[BIN_W-1:0] : '0;
                    r_err      <= r_mode & (r_err_acc | w_digit_err);
                end
            end
        end
    end

    assign bcd_out  = r_bcd_out;
    assign bin_out  = r_bin_out;
    assign ovf      = r_ovf;
    assign err      = r_err;
    assign mode_out = r_mode_out;

endmodule
`default_nettype wire

// File: tb/tb_bin_bcd_seq_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_bcd_seq_conv
// Description : Directed self-checking bench for bin_bcd_seq_conv. Instance A
//               uses BIN_W=20/DIGITS=6, instance B uses BIN_W=16/DIGITS=6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_bcd_seq_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_ready;

    logic        in_valid_a, in_ready_a, mode_a, out_valid_a;
    logic        ovf_a, err_a, mode_out_a;
    logic [19:0] bin_a, bin_out_a;
    logic [23:0] bcd_a, bcd_out_a;

    logic        in_valid_b, in_ready_b, mode_b, out_valid_b;
    logic        ovf_b, err_b, mode_out_b;
    logic [15:0] bin_b, bin_out_b;
    logic [23:0] bcd_b, bcd_out_b;

    int n_vec  = 0;
    int n_miss = 0;
    int lat;

    always #5 clk = ~clk;

    bin_bcd_seq_conv #(.BIN_W(20), .DIGITS(6), .CNT_W(6)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .mode(mode_a),
        .bin_in(bin_a), .bcd_in(bcd_a),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .bcd_out(bcd_out_a), .bin_out(bin_out_a),
        .ovf(ovf_a), .err(err_a), .mode_out(mode_out_a)
    );

    bin_bcd_seq_conv #(.BIN_W(16), .DIGITS(6), .CNT_W(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .mode(mode_b),
        .bin_in(bin_b), .bcd_in(bcd_b),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .bcd_out(bcd_out_b), .bin_out(bin_out_b),
        .ovf(ovf_b), .err(err_b), .mode_out(mode_out_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request to instance A (sel=0) or B (sel=1) and wait for
    // out_valid; lat returns the number of edges after the acceptance edge.
    // Operands are inverted right after acceptance to show they are not reused.
    task automatic run(input bit sel, input logic m, input logic [19:0] b,
                       input logic [23:0] d, output int n);
        if (sel) begin
            check("in_ready_b_pre", {31'd0, in_ready_b}, 32'd1);
            mode_b = m; bin_b = b[15:0]; bcd_b = d; in_valid_b = 1'b1;
        end else begin
            check("in_ready_a_pre", {31'd0, in_ready_a}, 32'd1);
            mode_a = m; bin_a = b; bcd_a = d; in_valid_a = 1'b1;
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        mode_a = ~m; bin_a = ~b; bcd_a = ~d;
        mode_b = ~m; bin_b = ~b[15:0]; bcd_b = ~d;
        n = 0;
        while (((sel ? out_valid_b : out_valid_a) !== 1'b1) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_a(input string tag, input int n, input int exp_n,
                           input logic [23:0] e_bcd, input logic [19:0] e_bin,
                           input logic e_ovf, input logic e_err, input logic e_mode);
        check({tag, "_lat"},  n, exp_n);
        check({tag, "_bcd"},  {8'd0, bcd_out_a}, {8'd0, e_bcd});
        check({tag, "_bin"},  {12'd0, bin_out_a}, {12'd0, e_bin});
        check({tag, "_ovf"},  {31'd0, ovf_a}, {31'd0, e_ovf});
        check({tag, "_err"},  {31'd0, err_a}, {31'd0, e_err});
        check({tag, "_mode"}, {31'd0, mode_out_a}, {31'd0, e_mode});
    endtask

    task automatic release_out(input bit sel);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rel_out_valid", {31'd0, sel ? out_valid_b : out_valid_a}, 32'd0);
        check("rel_in_ready",  {31'd0, sel ? in_ready_b : in_ready_a}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0;
        in_valid_a = 1'b0; mode_a = 1'b0; bin_a = '0; bcd_a = '0;
        in_valid_b = 1'b0; mode_b = 1'b0; bin_b = '0; bcd_b = '0;
        @(posedge clk); #1;
        check("rst_in_ready",  {31'd0, in_ready_a}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("rst_bcd",       {8'd0, bcd_out_a}, 32'd0);
        check("rst_flags",     {29'd0, ovf_a, err_a, mode_out_a}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mode 0 conversions
        run(0, 1'b0, 20'd123456, 24'h0, lat);
        check_a("b2d_123456", lat, 20, 24'h123456, 20'd0, 1'b0, 1'b0, 1'b0);
        release_out(0);
        run(0, 1'b0, 20'hFFFFF, 24'h0, lat);
        check_a("b2d_fffff", lat, 20, 24'h048575, 20'd0, 1'b1, 1'b0, 1'b0);
        release_out(0);
        run(0, 1'b0, 20'd999999, 24'h0, lat);
        check_a("b2d_999999", lat, 20, 24'h999999, 20'd0, 1'b0, 1'b0, 1'b0);
        release_out(0);
        run(0, 1'b0, 20'd0, 24'h0, lat);
        check_a("b2d_zero", lat, 20, 24'h000000, 20'd0, 1'b0, 1'b0, 1'b0);
        release_out(0);

        // Mode 1 conversions
        run(0, 1'b1, 20'd0, 24'h999999, lat);
        check_a("d2b_999999", lat, 6, 24'h0, 20'd999999, 1'b0, 1'b0, 1'b1);
        release_out(0);
        run(0, 1'b1, 20'd0, 24'h12A456, lat);
        check_a("d2b_err", lat, 6, 24'h0, 20'd130456, 1'b0, 1'b1, 1'b1);
        release_out(0);
        run(0, 1'b1, 20'd0, 24'h000000, lat);
        check_a("d2b_zero", lat, 6, 24'h0, 20'd0, 1'b0, 1'b0, 1'b1);
        release_out(0);

        // Narrow instance: overflow boundary
        run(1, 1'b1, 20'd0, 24'h065536, lat);
        check("b_lat_65536", lat, 6);
        check("b_bin_65536", {16'd0, bin_out_b}, 32'd0);
        check("b_ovf_65536", {31'd0, ovf_b}, 32'd1);
        release_out(1);
        run(1, 1'b1, 20'd0, 24'h065535, lat);
        check("b_bin_65535", {16'd0, bin_out_b}, 32'h0000FFFF);
        check("b_ovf_65535", {31'd0, ovf_b}, 32'd0);
        check("b_err_65535", {31'd0, err_b}, 32'd0);
        release_out(1);
        run(1, 1'b1, 20'd0, 24'h999999, lat);
        check("b_bin_999999", {16'd0, bin_out_b}, 32'd16959);
        check("b_ovf_999999", {31'd0, ovf_b}, 32'd1);
        release_out(1);

        // Back-pressure in DONE with a competing request
        run(0, 1'b0, 20'd555555, 24'h0, lat);
        check_a("bp_first", lat, 20, 24'h555555, 20'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1'b1; mode_a = 1'b0; bin_a = 20'd7;
            @(posedge clk); #1;
            check("bp_in_ready",  {31'd0, in_ready_a}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid_a}, 32'd1);
            check("bp_bcd_hold",  {8'd0, bcd_out_a}, 32'h00555555);
        end
        in_valid_a = 1'b0;
        release_out(0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_dropped", {30'd0, in_ready_a, out_valid_a}, 32'd2);
        run(0, 1'b0, 20'd777, 24'h0, lat);
        check_a("bp_next", lat, 20, 24'h000777, 20'd0, 1'b0, 1'b0, 1'b0);
        release_out(0);

        // Asynchronous reset mid-RUN
        in_valid_a = 1'b1; mode_a = 1'b0; bin_a = 20'd123456;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_bcd",       {8'd0, bcd_out_a}, 32'd0);
        check("ar_out_valid", {31'd0, out_valid_a}, 32'd0);
        check("ar_in_ready",  {31'd0, in_ready_a}, 32'd1);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar_post_state", {30'd0, in_ready_a, out_valid_a}, 32'd2);
        run(0, 1'b0, 20'd42, 24'h0, lat);
        check_a("ar_42", lat, 20, 24'h000042, 20'd0, 1'b0, 1'b0, 1'b0);
        release_out(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
